// File: rtl/input_pkg.sv
// Shared action encoding and opposing-pair helpers for the DAS top level and the scheduler.
package input_pkg;

  localparam int N_ACT = 6;

  typedef enum logic [2:0] {
    HARD_DROP = 3'd0,
    ROT_CW    = 3'd1,
    ROT_CCW   = 3'd2,
    LEFT      = 3'd3,
    RIGHT     = 3'd4,
    SOFT_DROP = 3'd5
  } action_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_LOCKOUT = 2'd2
  } sched_state_t;

  // Moves each bit onto its opposing partner; actions without a partner map to 0.
  function automatic logic [N_ACT-1:0] pair_swap(input logic [N_ACT-1:0] v);
    logic [N_ACT-1:0] s;
    s = '0;
    s[ROT_CW]  = v[ROT_CCW];
    s[ROT_CCW] = v[ROT_CW];
    s[LEFT]    = v[RIGHT];
    s[RIGHT]   = v[LEFT];
    return s;
  endfunction

endpackage

// File: rtl/action_scheduler_if.sv
// Command handshake between the scheduler (master) and the game logic (slave).
interface action_scheduler_if;
  logic               cmd_valid;
  input_pkg::action_t cmd_action;
  logic               cmd_ready;

  modport master (output cmd_valid, output cmd_action, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_action, output cmd_ready);
endinterface

// File: rtl/action_scheduler_counter.sv
// Up-counter with synchronous clear/load-to-zero and count enable.
module action_scheduler_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/action_scheduler.sv
// Queues DAS action pulses as pending bits and issues them one at a time to the game logic.
// state     | meaning
// S_IDLE    | waiting for a pending action; picks the lowest encoding first
// S_ISSUE   | cmd_valid held with a stable cmd_action until cmd_ready
// S_LOCKOUT | post-hard-drop suppression for LOCKOUT_CYCLES cycles
module action_scheduler #(
  parameter int N_ACT          = 6,
  parameter int LOCKOUT_CYCLES = 1_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_ACT-1:0]    act_pulse,
  output logic [N_ACT-1:0]    act_valid,
  input  logic                game_active,
  output logic                lockout,
  action_scheduler_if.master  cmd
);
  import input_pkg::*;

  localparam int             CW   = $clog2(LOCKOUT_CYCLES) + 1;
  localparam logic [CW-1:0]  LAST = CW'(LOCKOUT_CYCLES - 1);

  sched_state_t     r_state, w_state_next;
  action_t          r_act, w_act_next, w_pick;
  logic [N_ACT-1:0] r_pend, w_pend_next, w_accept, w_issue_clr;
  logic             w_clear_all, w_cnt_load, w_cnt_en;
  logic [CW-1:0]    w_count;

  action_scheduler_counter #(.WIDTH(CW)) u_lock_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_cnt_load),
    .i_en    (w_cnt_en),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_act   <= HARD_DROP;
    end else begin
      r_state <= w_state_next;
      r_pend  <= w_pend_next;
      r_act   <= w_act_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_act_next   = r_act;
    w_issue_clr  = '0;
    w_clear_all  = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_en     = 1'b0;
    w_pick       = HARD_DROP;

    for (int i = N_ACT - 1; i >= 0; i--) begin
      if (r_pend[i]) w_pick = action_t'(i[2:0]);
    end

    // A pulse is dropped if its bit is already set or its partner pulses in the same cycle.
    w_accept = (game_active && r_state != S_LOCKOUT)
             ? (act_pulse & ~r_pend & ~pair_swap(act_pulse)) : '0;

    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_act_next   = w_pick;
          w_issue_clr  = N_ACT'(1) << w_pick;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd.cmd_ready) begin
          if (r_act == HARD_DROP) begin
            w_state_next = S_LOCKOUT;
            w_cnt_load   = 1'b1;
            w_clear_all  = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        w_cnt_en = 1'b1;
        if (w_count == LAST) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    if (!game_active) begin
      w_state_next = S_IDLE;
      w_act_next   = r_act;
      w_clear_all  = 1'b1;
    end

    w_pend_next = w_clear_all ? '0
                : (((r_pend & ~w_issue_clr) & ~pair_swap(w_accept)) | w_accept);
  end

  always_comb begin
    act_valid = '0;
    for (int i = 0; i < N_ACT; i++) begin
      act_valid[i] = game_active && (r_state != S_LOCKOUT) && !r_pend[i]
                   && !(r_state == S_ISSUE && r_act == action_t'(i[2:0]));
    end
  end

  assign cmd.cmd_valid  = (r_state == S_ISSUE);
  assign cmd.cmd_action = r_act;
  assign lockout        = (r_state == S_LOCKOUT);

endmodule

// File: tb/tb_action_scheduler.sv
// Scoreboard bench: a cycle-level reference of the scheduling rules predicts every output and command order.
module tb_action_scheduler;
  localparam int NA = 6;
  localparam int LC = 8;
  localparam logic [5:0] P_HD  = 6'b000001;
  localparam logic [5:0] P_CW  = 6'b000010;
  localparam logic [5:0] P_CCW = 6'b000100;
  localparam logic [5:0] P_L   = 6'b001000;
  localparam logic [5:0] P_R   = 6'b010000;
  localparam logic [5:0] P_SD  = 6'b100000;

  logic clk = 1'b0;
  logic rst;
  logic [NA-1:0] act_pulse;
  logic [NA-1:0] act_valid;
  logic game_active;
  logic lockout;

  action_scheduler_if ifc ();

  action_scheduler #(.N_ACT(NA), .LOCKOUT_CYCLES(LC)) dut (
    .clk         (clk),
    .rst         (rst),
    .act_pulse   (act_pulse),
    .act_valid   (act_valid),
    .game_active (game_active),
    .lockout     (lockout),
    .cmd         (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  // Reference state: pending set, the command on offer, and lockout cycles remaining.
  bit m_pend[NA];
  bit m_issue;
  int m_act;
  int m_left;

  function automatic int opp(input int i);
    case (i)
      1: return 2;
      2: return 1;
      3: return 4;
      4: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(input string name, input int got, input int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NA; i++) m_pend[i] = 1'b0;
    m_issue = 1'b0;
    m_act   = 0;
    m_left  = 0;
  endtask

  task automatic model_step(input logic [5:0] p, input bit rdy, input bit g, input bit r);
    bit old[NA];
    bit acc[NA];
    int o;
    if (r) begin
      model_reset();
      return;
    end
    if (!g) begin
      for (int i = 0; i < NA; i++) m_pend[i] = 1'b0;
      m_issue = 1'b0;
      m_left  = 0;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      return;
    end
    old = m_pend;
    if (m_issue) begin
      if (rdy) begin
        m_issue = 1'b0;
        if (m_act == 0) begin
          m_left = LC;
          for (int i = 0; i < NA; i++) m_pend[i] = 1'b0;
          return;
        end
      end
    end else begin
      for (int i = 0; i < NA; i++) begin
        if (old[i]) begin
          m_act     = i;
          m_issue   = 1'b1;
          m_pend[i] = 1'b0;
          break;
        end
      end
    end
    for (int i = 0; i < NA; i++) begin
      o = opp(i);
      acc[i] = p[i] && !old[i];
      if (o >= 0 && p[o]) acc[i] = 1'b0;
    end
    for (int i = 0; i < NA; i++) begin
      if (acc[i]) begin
        m_pend[i] = 1'b1;
        o = opp(i);
        if (o >= 0) m_pend[o] = 1'b0;
      end
    end
  endtask

  task automatic cyc(input logic [5:0] p, input bit rdy, input bit g, input bit r);
    logic [NA-1:0] exp_av;
    bit lk;
    act_pulse     = p;
    ifc.cmd_ready = rdy;
    game_active   = g;
    rst           = r;
    @(negedge clk);
    lk = (m_left > 0);
    for (int i = 0; i < NA; i++)
      exp_av[i] = g && !lk && !m_pend[i] && !(m_issue && m_act == i);
    check("cmd_valid", int'(ifc.cmd_valid), int'(m_issue));
    check("lockout", int'(lockout), int'(lk));
    check("act_valid", int'(act_valid), int'(exp_av));
    if (m_issue) begin
      check("cmd_action", int'(ifc.cmd_action), m_act);
      if (rdy) exp_q.push_back(m_act);
    end
    model_step(p, rdy, g, r);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(6'b0, rdy, 1'b1, 1'b0);
  endtask

  // Monitor: every accepted command must match the oldest predicted one.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      #1;
      if (ifc.cmd_valid === 1'b1 && ifc.cmd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got action %0d expected none", ifc.cmd_action);
        end else begin
          e = exp_q.pop_front();
          check("sb_order", int'(ifc.cmd_action), e);
        end
      end
    end
  end

  initial begin
    int lc;
    rst = 1'b1;
    act_pulse = '0;
    game_active = 1'b1;
    ifc.cmd_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cyc(P_L, 1'b0, 1'b1, 1'b1);

    // Single LEFT: issued two cycles after the pulse.
    cyc(P_L, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Three simultaneous pulses: priority order 1, 3, 5.
    cyc(P_CW | P_L | P_SD, 1'b1, 1'b1, 1'b0);
    idle(8, 1'b1);

    // Simultaneous LEFT+RIGHT is dropped entirely.
    cyc(P_L | P_R, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b1);

    // Latest-wins while a HARD_DROP is stalled, then lockout length.
    cyc(P_HD, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    cyc(P_L, 1'b0, 1'b1, 1'b0);
    cyc(P_R, 1'b0, 1'b1, 1'b0);
    cyc(P_L | P_R, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    lc = 0;
    cyc(6'b0, 1'b1, 1'b1, 1'b0);
    if (lockout === 1'b1) lc++;
    for (int k = 0; k < 14; k++) begin
      cyc((k % 2 == 0) ? P_SD : P_CCW, 1'b1, 1'b1, 1'b0);
      if (lockout === 1'b1) lc++;
    end
    check("lockout_len", lc, LC);
    idle(4, 1'b1);

    // Stall with stable command, then game_active drop aborts.
    cyc(P_L | P_SD, 1'b0, 1'b1, 1'b0);
    idle(6, 1'b0);
    cyc(6'b0, 1'b0, 1'b0, 1'b0);
    idle(4, 1'b1);

    // Reset mid-LOCKOUT and mid-ISSUE.
    cyc(P_HD, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1);
    cyc(P_L, 1'b1, 1'b1, 1'b1);
    idle(2, 1'b1);
    cyc(P_CW, 1'b0, 1'b1, 1'b0);
    idle(3, 1'b0);
    cyc(P_R, 1'b0, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [5:0] p;
      p = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      cyc(p, $urandom_range(0, 2) != 0, $urandom_range(0, 49) != 0, $urandom_range(0, 199) == 0);
    end
    idle(20, 1'b1);

    check("sb_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
